// File: rtl/branch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | branch_pkg : shared RV32I branch funct3 codes, FSM state type, decode helpers
// | Rev 1.0
// +-----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // 010 and 011 are the reserved encodings in the branch opcode space
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      BEQ:         t = eq;
      BNE:         t = ~eq;
      BLT,  BLTU:  t = lt;
      BGE,  BGEU:  t = ~lt;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | branch_resolve_if : branch presentation, comparator, redirect and status bus
// | Rev 1.0
// +-----------------------------------------------------------------------------
interface branch_resolve_if;

  logic        br_valid;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        BrEq;
  logic        BrLt;
  logic        BrUn;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic        misalign;
  logic        illegal;
  logic [31:0] br_count;
  logic [31:0] taken_count;

  modport master (
    output br_valid, br_funct3, br_pc, br_imm, BrEq, BrLt, redirect_ready,
    input  BrUn, redirect_valid, redirect_pc, flush, stall, misalign, illegal,
           br_count, taken_count
  );

  modport slave (
    input  br_valid, br_funct3, br_pc, br_imm, BrEq, BrLt, redirect_ready,
    output BrUn, redirect_valid, redirect_pc, flush, stall, misalign, illegal,
           br_count, taken_count
  );

endinterface : branch_resolve_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sat_counter : up-counter with increment enable that sticks at all-ones
// | Rev 1.0
// +-----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_en,
  output logic [WIDTH-1:0]      o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | branch_resolve : resolves conditional branches, issues fetch redirect + flush
// | Rev 1.0
// +-----------------------------------------------------------------------------
module branch_resolve
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  branch_resolve_if.slave   bif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic [31:0] r_target;
  logic        r_misalign;
  logic        r_illegal;

  logic        w_accept;
  logic        w_legal;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_go;

  assign w_accept = bif.br_valid && (r_state == ST_IDLE);
  assign w_legal  = f3_legal(bif.br_funct3);
  assign w_taken  = w_legal && f3_taken(bif.br_funct3, bif.BrEq, bif.BrLt);
  assign w_target = bif.br_pc + bif.br_imm;
  assign w_go     = w_accept && w_taken && (w_target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_go) w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bif.redirect_ready) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = 3'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        if (r_flush_cnt <= 3'd1) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Target captured only for redirecting branches so redirect_pc stays frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target   <= 32'd0;
      r_misalign <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_misalign <= w_accept && w_taken && (w_target[1:0] != 2'b00);
      r_illegal  <= w_accept && !w_legal;
      if (w_go) r_target <= w_target;
    end
  end

  sat_counter #(.WIDTH(32)) u_br_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept && w_legal),
    .o_count (bif.br_count)
  );

  sat_counter #(.WIDTH(32)) u_taken_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_accept && w_taken),
    .o_count (bif.taken_count)
  );

  assign bif.BrUn           = (bif.br_funct3 == BLTU) || (bif.br_funct3 == BGEU);
  assign bif.redirect_valid = (r_state == ST_REDIRECT);
  assign bif.redirect_pc    = r_target;
  assign bif.flush          = (r_state == ST_FLUSH);
  assign bif.stall          = (r_state != ST_IDLE);
  assign bif.misalign       = r_misalign;
  assign bif.illegal        = r_illegal;

endmodule : branch_resolve
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_branch_resolve : randomized + directed bench with an operand-level model
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_branch_resolve;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] exp_br;
  logic [31:0] exp_tk;

  branch_resolve_if bif ();

  branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  // Reference semantics on the actual operands, not on comparator flags
  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b, input int dly, input bit noise);
    bit          un, legal, tk, redir, mis;
    logic [31:0] tgt;
    un    = (f3 == 3'd6) || (f3 == 3'd7);
    legal = !((f3 == 3'd2) || (f3 == 3'd3));
    tk    = legal && ref_taken(f3, a, b);
    tgt   = pc + imm;
    redir = tk && (tgt[1:0] == 2'b00);
    mis   = tk && !redir;
    bif.br_valid  = 1'b1;
    bif.br_funct3 = f3;
    bif.br_pc     = pc;
    bif.br_imm    = imm;
    bif.BrEq      = (a == b);
    bif.BrLt      = un ? (a < b) : ($signed(a) < $signed(b));
    #1;
    n_total++; if (bif.BrUn !== un) $display("FAIL brun: got %0b want %0b f3=%0d", bif.BrUn, un, f3); else n_pass++;
    n_total++; if (bif.stall !== 1'b0) $display("FAIL stall_idle: got %0b want 0", bif.stall); else n_pass++;
    @(posedge clk); #1;
    // A tempting taken BEQ while busy; it must be ignored
    bif.br_valid  = redir ? noise : 1'b0;
    bif.br_funct3 = 3'd0;
    bif.BrEq      = 1'b1;
    bif.br_imm    = 32'h40;
    if (legal && exp_br != 32'hFFFF_FFFF) exp_br++;
    if (tk && exp_tk != 32'hFFFF_FFFF) exp_tk++;
    n_total++; if (bif.redirect_valid !== redir) $display("FAIL rv_n1: got %0b want %0b", bif.redirect_valid, redir); else n_pass++;
    n_total++; if (bif.stall !== redir) $display("FAIL stall_n1: got %0b want %0b", bif.stall, redir); else n_pass++;
    n_total++; if (bif.misalign !== mis) $display("FAIL misalign: got %0b want %0b", bif.misalign, mis); else n_pass++;
    n_total++; if (bif.illegal !== !legal) $display("FAIL illegal: got %0b want %0b", bif.illegal, !legal); else n_pass++;
    n_total++; if (bif.br_count !== exp_br) $display("FAIL br_count: got %h want %h", bif.br_count, exp_br); else n_pass++;
    n_total++; if (bif.taken_count !== exp_tk) $display("FAIL taken_count: got %h want %h", bif.taken_count, exp_tk); else n_pass++;
    if (redir) begin
      n_total++; if (bif.redirect_pc !== tgt) $display("FAIL redirect_pc: got %h want %h", bif.redirect_pc, tgt); else n_pass++;
      bif.redirect_ready = 1'b0;
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        n_total++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== tgt || bif.stall !== 1'b1)
          $display("FAIL rv_hold: got v=%0b pc=%h s=%0b want 1 %h 1", bif.redirect_valid, bif.redirect_pc, bif.stall, tgt);
        else n_pass++;
        n_total++; if (bif.br_count !== exp_br || bif.taken_count !== exp_tk)
          $display("FAIL cnt_hold: got %h/%h want %h/%h", bif.br_count, bif.taken_count, exp_br, exp_tk);
        else n_pass++;
      end
      bif.redirect_ready = 1'b1;
      for (int i = 0; i < FC; i++) begin
        @(posedge clk); #1;
        bif.redirect_ready = 1'($urandom_range(0, 1));
        n_total++; if (bif.flush !== 1'b1 || bif.stall !== 1'b1 || bif.redirect_valid !== 1'b0)
          $display("FAIL flush_cyc%0d: got f=%0b s=%0b v=%0b want 1 1 0", i, bif.flush, bif.stall, bif.redirect_valid);
        else n_pass++;
      end
      @(posedge clk); #1;
      bif.br_valid       = 1'b0;
      bif.redirect_ready = 1'b0;
      n_total++; if (bif.flush !== 1'b0 || bif.stall !== 1'b0)
        $display("FAIL flush_end: got f=%0b s=%0b want 0 0", bif.flush, bif.stall);
      else n_pass++;
      n_total++; if (bif.br_count !== exp_br) $display("FAIL cnt_after: got %h want %h", bif.br_count, exp_br); else n_pass++;
    end else begin
      @(posedge clk); #1;
      n_total++; if (bif.misalign !== 1'b0 || bif.illegal !== 1'b0 || bif.redirect_valid !== 1'b0)
        $display("FAIL pulse_end: got m=%0b i=%0b v=%0b want 0 0 0", bif.misalign, bif.illegal, bif.redirect_valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.br_valid = 1'b0; bif.br_funct3 = 3'd0; bif.br_pc = 32'd0; bif.br_imm = 32'd0;
    bif.BrEq = 1'b0; bif.BrLt = 1'b0; bif.redirect_ready = 1'b0;
    exp_br = 32'd0; exp_tk = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({bif.redirect_valid, bif.flush, bif.stall, bif.misalign, bif.illegal} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {bif.redirect_valid, bif.flush, bif.stall, bif.misalign, bif.illegal});
    else n_pass++;
    n_total++; if (bif.redirect_pc !== 32'd0 || bif.br_count !== 32'd0 || bif.taken_count !== 32'd0)
      $display("FAIL reset_regs: got %h %h %h want 0", bif.redirect_pc, bif.br_count, bif.taken_count);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq_redirect();
    do_branch(3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 0, 1'b0);
  endtask

  task automatic test_bltu_not_taken();
    do_branch(3'd6, 32'h300, 32'h10, 32'd5, 32'd3, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_branch(3'd1, 32'h1000, 32'hFFFF_FF00, 32'd1, 32'd2, 5, 1'b1);
  endtask

  task automatic test_misalign();
    do_branch(3'd5, 32'h0, 32'hFFFF_FFFE, 32'd9, 32'd9, 0, 1'b0);
  endtask

  task automatic test_illegal();
    do_branch(3'd2, 32'h40, 32'h8, 32'd1, 32'd1, 0, 1'b0);
    do_branch(3'd3, 32'h40, 32'h8, 32'd1, 32'd2, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b, pc, imm;
    for (int n = 0; n < 40; n++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
      do_branch(3'($urandom_range(0, 7)), pc, imm, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_flush();
    bif.br_valid = 1'b1; bif.br_funct3 = 3'd0; bif.br_pc = 32'h200; bif.br_imm = 32'h40; bif.BrEq = 1'b1;
    @(posedge clk); #1;
    bif.br_valid = 1'b0; bif.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bif.redirect_ready = 1'b0;
    n_total++; if (bif.flush !== 1'b1) $display("FAIL pre_reset_flush: got %0b want 1", bif.flush); else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_br = 32'd0; exp_tk = 32'd0;
    n_total++; if ({bif.redirect_valid, bif.flush, bif.stall, bif.misalign, bif.illegal} !== 5'b0 ||
                   bif.redirect_pc !== 32'd0 || bif.br_count !== 32'd0 || bif.taken_count !== 32'd0)
      $display("FAIL async_reset: got v=%0b f=%0b s=%0b pc=%h bc=%h want all 0",
               bif.redirect_valid, bif.flush, bif.stall, bif.redirect_pc, bif.br_count);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_total++; if (bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0 || bif.stall !== 1'b0)
        $display("FAIL post_reset_idle: got v=%0b f=%0b s=%0b want 0 0 0", bif.redirect_valid, bif.flush, bif.stall);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    force dut.u_br_cnt.r_count    = 32'hFFFF_FFFD;
    force dut.u_taken_cnt.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_br_cnt.r_count;
    release dut.u_taken_cnt.r_count;
    exp_br = 32'hFFFF_FFFD;
    exp_tk = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) do_branch(3'd0, 32'h80, 32'h4, 32'd3, 32'd3, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq_redirect();
    test_bltu_not_taken();
    test_backpressure();
    test_misalign();
    test_illegal();
    test_random();
    test_reset_flush();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_branch_resolve
`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a redirect handshake; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 br_valid  input  1  a conditional branch is presented this cycle.
REQ-005 br_funct3  input  3  RV32I branch funct3 of the presented branch.
REQ-006 br_pc  input  32  PC of the presented branch.
REQ-007 br_imm  input  32  sign-extended B-type offset.
REQ-008 BrEq  input  1  equality result from the branch comparator.
REQ-009 BrLt  input  1  less-than result from the branch comparator.
REQ-010 BrUn  output  1  comparator mode select, 1 = unsigned compare.
REQ-011 redirect_valid  output  1  redirect request to fetch.
REQ-012 redirect_ready  input  1  fetch accepts redirect.
REQ-013 redirect_pc  output  32  branch target.
REQ-014 flush  output  1  squash younger instructions.
REQ-015 stall  output  1  upstream shall hold its branch; block not accepting.
REQ-016 misalign  output  1  one-cycle pulse: taken target not word-aligned.
REQ-017 illegal  output  1  one-cycle pulse: reserved funct3.
REQ-018 br_count  output  32  accepted legal branches, saturating.
REQ-019 taken_count  output  32  taken branches (incl. misaligned), saturating.

Function
REQ-020 BrUn SHALL be combinational: 1 when br_funct3 is 110 or 111, else 0, regardless of state.
REQ-021 A branch SHALL be accepted in a cycle when br_valid=1 and stall=0; otherwise br_valid is ignored.
REQ-022 Taken decode: 000 BrEq; 001 !BrEq; 100/110 BrLt; 101/111 !BrLt; 010/011 illegal, never taken.
REQ-023 Target SHALL be br_pc + br_imm modulo 2^32, computed at acceptance.
REQ-024 FSM states IDLE, REDIRECT, FLUSH; reset state IDLE.
REQ-025 IDLE: accepted taken branch with target[1:0]=00 -> REDIRECT next cycle; misaligned -> misalign=1 next cycle, stay IDLE; not-taken or illegal -> stay IDLE.
REQ-026 REDIRECT: redirect_valid=1, redirect_pc registered target, both stable until handshake (redirect_valid & redirect_ready); handshake cycle -> FLUSH.
REQ-027 FLUSH: flush=1 for exactly FLUSH_CYCLES cycles via down-counter, then IDLE.
REQ-028 stall SHALL be 1 in REDIRECT and FLUSH, 0 in IDLE.
REQ-029 Latency: acceptance cycle N -> redirect_valid at N+1; with redirect_ready=1 at N+1, flush during N+2..N+1+FLUSH_CYCLES, stall=0 at N+2+FLUSH_CYCLES.
REQ-030 illegal SHALL pulse one cycle after acceptance of a reserved funct3; counters unchanged.
REQ-031 br_count SHALL increment one cycle after every accepted legal branch; taken_count additionally when taken; both hold at 0xFFFFFFFF.
REQ-032 redirect_ready in IDLE or FLUSH SHALL have no effect.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, redirect_valid=0, redirect_pc=0, flush=0, stall=0, misalign=0, illegal=0, counters=0, flush counter=0.
REQ-034 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abandon the operation with no redirect after release.

Structure
REQ-035 Shared package branch_pkg SHALL hold funct3 constants (BEQ..BGEU) and the state enum.
REQ-036 One sub-module sat_counter (32-bit, increment enable, saturating) SHALL be instanced twice for the counters.

Verification
REQ-037 BEQ, BrEq=1, br_pc=0x100, br_imm=0x20, redirect_ready=1 -> redirect_pc=0x120 at N+1, flush 2 cycles, taken_count=1.
REQ-038 BLTU, BrLt=0 -> BrUn=1 same cycle, no redirect, br_count=1, taken_count=0, stall stays 0.
REQ-039 BNE taken, redirect_ready low 5 cycles -> redirect_valid/redirect_pc stable 5 cycles, second br_valid ignored, stall=1 throughout.
REQ-040 BGE taken, br_pc=0x0, br_imm=0xFFFFFFFE -> misalign pulse, no redirect, taken_count=1.
REQ-041 funct3=010 -> illegal pulse, counters unchanged; rst_n low during FLUSH -> all outputs 0 immediately.
REQ-042 Counters preloaded near 0xFFFFFFFF via forced 4 taken branches -> both saturate at 0xFFFFFFFF.
